// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage DLX pipeline: load-use bubble, multiplier freeze, branch flush.
// Outputs are Mealy (same cycle as inputs); stall_count is registered and saturates.
module pipeline_stall_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_hazard,
  input  logic             mul_id,
  input  logic             branch_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             mul_busy,
  output logic [0:CNT_W-1] stall_count
);

  typedef enum logic [1:0] {RUN, LD_HOLD, MUL_WAIT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         mcnt_q, mcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    mul_busy     = 1'b0;
    state_d      = state_q;
    mcnt_d       = mcnt_q;
    if (!rst_n) begin
      state_d = RUN;
      mcnt_d  = 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (load_hazard) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            state_d     = LD_HOLD;
          end else begin
            ifid_flush = branch_taken;
            if (mul_id) begin
              state_d = MUL_WAIT;
              mcnt_d  = 4'(MUL_CYCLES - 1);
            end
          end
        end
        // The load-use detector still sees the bubble's stale compare here; ignore it.
        LD_HOLD: begin
          ifid_flush = branch_taken;
          if (mul_id) begin
            state_d = MUL_WAIT;
            mcnt_d  = 4'(MUL_CYCLES - 1);
          end else begin
            state_d = RUN;
          end
        end
        MUL_WAIT: begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_we      = 1'b0;
          exmem_bubble = 1'b1;
          mul_busy     = 1'b1;
          if (mcnt_q <= 4'd1) begin
            state_d = RUN;
            mcnt_d  = 4'd0;
          end else begin
            mcnt_d = mcnt_q - 4'd1;
          end
        end
        default: begin
          state_d = RUN;
          mcnt_d  = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!pc_we && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      mcnt_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ascending output range: leftmost bit (index 0) carries the MSB.
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed vector table, randomized run against a cycle model, saturation check.
module tb_pipeline_stall_ctrl;
  localparam int MUL_CYCLES = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, load_hazard, mul_id, branch_taken;
  logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, mul_busy;
  logic [0:CNT_W-1] stall_count;

  pipeline_stall_ctrl #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_hazard(load_hazard), .mul_id(mul_id),
    .branch_taken(branch_taken), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble), .mul_busy(mul_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: remaining frozen cycles of a multiply, whether a load bubble was just issued, stall total.
  int m_frz  = 0;
  bit m_hold = 1'b0;
  int m_cnt  = 0;

  // Output vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, mul_busy}
  function automatic logic [6:0] model_out(bit r, bit l, bit b);
    if (!r)                return 7'b1101000;
    if (m_frz > 0)         return 7'b0000011;
    if (!m_hold && l)      return 7'b0001100;
    return {2'b11, b, 4'b1000};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit l, input bit m, input bit b,
                       output logic [6:0] got, output int gotc,
                       output logic [6:0] mexp, output int mcnt);
    rst_n = r; load_hazard = l; mul_id = m; branch_taken = b;
    @(negedge clk);
    got  = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, mul_busy};
    gotc = int'(stall_count);
    mexp = model_out(r, l, b);
    mcnt = m_cnt;
    @(posedge clk);
    if (!r) begin
      m_frz = 0; m_hold = 1'b0; m_cnt = 0;
    end else begin
      if (!mexp[6] && m_cnt < CNT_MAX) m_cnt++;
      if (m_frz > 0) m_frz--;
      else if (!m_hold && l) m_hold = 1'b1;
      else begin
        m_hold = 1'b0;
        if (m) m_frz = MUL_CYCLES - 1;
      end
    end
    #1;
  endtask

  typedef struct {
    bit r, l, m, b;
    logic [6:0] exp;
    int cnt;
  } vec_t;

  vec_t vt[20];

  initial begin
    logic [6:0] got, mexp;
    int gotc, mcnt;

    vt[0]  = '{0,1,1,1, 7'b1101000, 0};  // reset with all inputs high
    vt[1]  = '{0,1,1,1, 7'b1101000, 0};
    vt[2]  = '{1,1,0,0, 7'b0001100, 0};  // load-use bubble
    vt[3]  = '{1,1,0,0, 7'b1101000, 1};  // LD_HOLD ignores hazard
    vt[4]  = '{1,0,0,0, 7'b1101000, 1};
    vt[5]  = '{1,0,1,0, 7'b1101000, 1};  // multiply enters EX
    vt[6]  = '{1,0,0,0, 7'b0000011, 1};
    vt[7]  = '{1,0,0,0, 7'b0000011, 2};
    vt[8]  = '{1,0,0,0, 7'b0000011, 3};
    vt[9]  = '{1,0,0,0, 7'b1101000, 4};
    vt[10] = '{1,0,1,1, 7'b1111000, 4};  // multiply with branch flush
    vt[11] = '{1,0,0,1, 7'b0000011, 4};
    vt[12] = '{1,0,0,1, 7'b0000011, 5};
    vt[13] = '{1,0,0,1, 7'b0000011, 6};
    vt[14] = '{1,0,0,1, 7'b1111000, 7};  // branch re-evaluated after release
    vt[15] = '{1,1,1,1, 7'b0001100, 7};  // load hazard wins
    vt[16] = '{1,1,1,0, 7'b1101000, 8};  // LD_HOLD takes the multiply
    vt[17] = '{1,0,0,0, 7'b0000011, 8};
    vt[18] = '{0,0,0,0, 7'b1101000, 9};  // reset aborts the wait
    vt[19] = '{1,0,0,0, 7'b1101000, 0};

    rst_n = 1'b0; load_hazard = 1'b0; mul_id = 1'b0; branch_taken = 1'b0;
    @(posedge clk); #1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, got, gotc, mexp, mcnt);

    for (int i = 0; i < 20; i++) begin
      cycle(vt[i].r, vt[i].l, vt[i].m, vt[i].b, got, gotc, mexp, mcnt);
      check($sformatf("vec%0d_out", i), 32'(got), 32'(vt[i].exp));
      check($sformatf("vec%0d_cnt", i), 32'(gotc), 32'(vt[i].cnt));
    end

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30),
            got, gotc, mexp, mcnt);
      check($sformatf("rand%0d_out", i), 32'(got), 32'(mexp));
      check($sformatf("rand%0d_cnt", i), 32'(gotc), 32'(mcnt));
    end

    // 7 back-to-back multiplies give 21 stall cycles, past the 4-bit limit.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, got, gotc, mexp, mcnt);
    for (int i = 0; i < 7 * MUL_CYCLES; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, got, gotc, mexp, mcnt);
      check($sformatf("sat%0d_out", i), 32'(got), 32'(mexp));
    end
    @(negedge clk);
    check("sat_final", 32'(stall_count), 32'(CNT_MAX));
    @(posedge clk); #1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, got, gotc, mexp, mcnt);
    check("sat_hold", 32'(gotc), 32'(CNT_MAX));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, got, gotc, mexp, mcnt);
    @(negedge clk);
    check("sat_reset_clear", 32'(stall_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
